ram_pixel_streamer: RTL
=======================

// Module: ram_pixel_streamer
// PURPOSE
//  Reader end of the image RAM: after the halftone pass finishes, scans the 512x512 8-bit
//  image RAM in raster order and streams one pixel per beat over a valid/ready interface
//  (display/UART/DMA sink). Absorbs the RAM's 1-cycle read latency and sink backpressure
//  with a 2-entry buffer. It owns the RAM read port only and never writes.
// PARAMETERS
//  IMG_W       512  pixels per row (power of 2)
//  IMG_H       512  rows per frame (power of 2)
//  ADDR_W      18   RAM address width, equal to log2(IMG_W*IMG_H)
//  DATA_W      8    pixel width
//  FIFO_DEPTH  2    output buffer entries (>=2 for 1 pixel/cycle)
// PORTS
//  clk        in   1       single clock, all logic posedge
//  rst_n      in   1       asynchronous, active-low reset (negedge)
//  start      in   1       1-cycle pulse, typically diff_done; ignored unless IDLE
//  busy       out  1       high from the cycle after accepted start until done
//  done       out  1       1-cycle pulse after the last pixel handshake
//  ram_ren    out  1       RAM read enable; data returns on ram_odata next cycle
//  ram_addr   out  ADDR_W  RAM read address = row*IMG_W + col
//  ram_odata  in   DATA_W  RAM read data, valid 1 cycle after ram_ren
//  m_valid    out  1       pixel beat valid
//  m_ready    in   1       sink accepts beat when m_valid&m_ready
//  m_data     out  DATA_W  pixel value
//  m_sof      out  1       qualifies beat at (0,0)
//  m_eol      out  1       qualifies beat with col==IMG_W-1
//  m_eof      out  1       qualifies last beat (IMG_W*IMG_H-1)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, ram_ren, m_valid, m_sof, m_eol, m_eof = 0; ram_addr, m_data = 0;
//   FIFO empty; in-flight flag cleared. Reset mid-frame aborts; no partial beats afterwards.
//  FSM: IDLE --start--> RUN; RUN --last address issued--> DRAIN; DRAIN --last beat
//   accepted--> DONE; DONE --(1 cycle, done=1)--> IDLE.
//  Issue rule (RUN only): ram_ren=1 iff (occ + infl - pop) < FIFO_DEPTH, where occ is
//   FIFO occupancy, infl the read returning this cycle, and pop = m_valid&m_ready.
//   Each issue increments rd_addr; at IMG_W*IMG_H-1 the FSM moves to DRAIN with no wrap.
//  Return: infl read pushes {ram_odata, sof, eol, eof} into the FIFO at the end of the
//   return cycle. Flags are computed from the issued address and travel with the data.
//  Latency: start seen at cycle 0 -> ram_ren at cycle 1 (addr 0) -> first m_valid at cycle 3.
//   With m_ready held high, throughput is 1 beat/cycle and the frame takes IMG_W*IMG_H+3 cycles.
//  Handshake: once m_valid=1, m_data and the flags stay stable until accepted. m_valid is
//   never withdrawn without acceptance. The FIFO never overflows, because the issue rule
//   guarantees space. A simultaneous push and pop at full occupancy is legal.
//  done asserts exactly 1 cycle after the eof handshake. busy falls in the same cycle.
//  A start pulse while busy or in DONE is ignored. A new start in IDLE restarts from addr 0.
//  ram_addr holds its last value when ram_ren=0.
// STRUCTURE
//  img_defs.vh: IMG_W, IMG_H, ADDR_W, DATA_W and state encodings (IDLE/RUN/DRAIN/DONE).
//   These are shared with top and the grayscale path.
//  Sub-module pix_fifo: synchronous FIFO of width DATA_W+3 and depth FIFO_DEPTH, with
//   push, pop, occ, full and empty; output taken from the registered head entry.
//  The top level holds the FSM, row/col counters, issue logic and in-flight flag.
// TESTING
//  1 m_ready=1, RAM[i]=i[7:0], start pulse -> 262144 beats, data i[7:0] in order;
//    first m_valid 3 cycles after start; done 1 cycle after eof beat.
//  2 m_ready random 50% -> identical data order; m_data stable while valid&!ready;
//    occupancy never above 2; ram_ren never exceeds credit.
//  3 Flags -> m_sof only on beat 0; m_eol on beats 511, 1023, ..., 262143;
//    m_eof only on beat 262143, coincident with m_eol.
//  4 m_ready=0 for 100 cycles after first valid -> exactly 2 reads issued, no more;
//    release -> stream resumes at pixel 2 with no loss or duplication.
//  5 rst_n low at pixel 1000 -> all outputs 0 immediately; new start -> restarts at addr 0, sof first.
//  6 Extra start pulses while busy -> ignored, single done pulse, beat count 262144.

Source files
------------

// File: rtl/ram_pixel_streamer_pkg.sv
// Shared image geometry, pixel-beat flag layout and FSM encoding for the
// image RAM reader and the grayscale path.
package ram_pixel_streamer_pkg;

  localparam int DEF_IMG_W      = 512;
  localparam int DEF_IMG_H      = 512;
  localparam int DEF_ADDR_W     = 18;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  // Sideband flags travel above the pixel byte inside each buffered entry.
  localparam int FLAG_W  = 3;
  localparam int SOF_BIT = 0;
  localparam int EOL_BIT = 1;
  localparam int EOF_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_pixel_streamer_pix_fifo.sv
// Small synchronous FIFO; the output is the registered head entry, so a
// beat stays stable until it is popped.
module ram_pixel_streamer_pix_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is accepted only when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/ram_pixel_streamer.sv
// Raster-order reader of the image RAM: issues reads under a credit limit,
// buffers returning pixels with their frame flags and streams them valid/ready.
module ram_pixel_streamer
  import ram_pixel_streamer_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_odata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers on a cycle where m_valid && m_ready; once
  // m_valid rises, m_data and the flags hold until that transfer happens.

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = DATA_W + FLAG_W;

  state_e state;
  state_e state_nxt;

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               last_col;
  logic               last_pix;
  logic               issue;
  logic               pop;
  logic               infl;
  logic [FLAG_W-1:0]  infl_flags;
  logic [FLAG_W-1:0]  addr_flags;
  logic [OCC_W:0]     credit_used;

  logic [ENTRY_W-1:0] fifo_head;
  logic [OCC_W-1:0]   fifo_occ;
  logic               fifo_full;
  logic               fifo_empty;

  assign last_col = &col;
  assign last_pix = last_col && (&row);
  assign ram_addr = ADDR_W'({row, col});
  assign dbg_state = state;

  always_comb begin
    addr_flags          = '0;
    addr_flags[SOF_BIT] = (row == '0) && (col == '0);
    addr_flags[EOL_BIT] = last_col;
    addr_flags[EOF_BIT] = last_pix;
  end

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_head[DATA_W-1:0];
  assign m_sof   = fifo_head[DATA_W + SOF_BIT];
  assign m_eol   = fifo_head[DATA_W + EOL_BIT];
  assign m_eof   = fifo_head[DATA_W + EOF_BIT];

  // Entries already held, plus the read landing now, minus the beat leaving now.
  assign credit_used = {1'b0, fifo_occ} + (OCC_W + 1)'(infl) - (OCC_W + 1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (issue && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && m_eof) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_RUN: begin
        busy  = 1'b1;
        issue = (credit_used < (OCC_W + 1)'(FIFO_DEPTH));
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign ram_ren = issue;

  // The address stays on the last pixel after the final issue; no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (state == ST_IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (issue && !last_pix) begin
      col <= col + COL_W'(1);
      if (last_col) row <= row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl       <= 1'b0;
      infl_flags <= '0;
    end else begin
      infl <= issue;
      if (issue) infl_flags <= addr_flags;
    end
  end

  ram_pixel_streamer_pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl),
    .push_data ({infl_flags, ram_odata}),
    .pop       (pop),
    .head      (fifo_head),
    .occ       (fifo_occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(infl && fifo_full && !pop));

endmodule
